// File: rtl/scmp_arb_pkg.sv
// Shared types and helpers for the scmp bus arbiter: state encoding, requester limit,
// and the round-robin search used by the picker.
package scmp_arb_pkg;

  localparam int unsigned NREQ_MAX = 4;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDrain,
    StTurn
  } arb_state_e;

  // Returns {found, index}; the search begins one past 'last' and wraps modulo n.
  function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] req,
                                         input logic [1:0]          last,
                                         input int unsigned         n);
    logic [2:0] n3;
    logic [2:0] cand;
    logic [2:0] res;
    n3  = 3'(n);
    res = '0;
    for (int k = 1; k <= NREQ_MAX; k++) begin
      cand = {1'b0, last} + 3'(k);
      if (cand >= n3) cand = cand - n3;
      if (3'(k) <= n3 && !res[2] && req[cand[1:0]]) res = {1'b1, cand[1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/scmp_arb_rr.sv
// Combinational round-robin picker: request vector and last owner in, one-hot winner,
// winner index and a valid flag out.
module scmp_arb_rr
  import scmp_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] win_oh,
  output logic [1:0]      win_idx,
  output logic            win_vld
);

  logic [NREQ_MAX-1:0] req_ext;
  logic [2:0]          pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    pick               = rr_pick(req_ext, last, NREQ);
    win_vld            = pick[2];
    win_idx            = pick[1:0];
    win_oh             = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      win_oh[i] = pick[2] && (pick[1:0] == 2'(i));
    end
  end

endmodule

// File: rtl/scmp_bus_arb.sv
// Round-robin bus arbiter with drain-on-activity and turnaround gap.
// Optional grant timeout and requester masking under `define SCMP_ARB_TIMEOUT_EN.
module scmp_bus_arb
  import scmp_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] breq,
  input  logic            bus_act,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      owner,
  output logic            busy,
  output logic            tmo
);

  localparam logic [1:0] TurnLoad = (TURN_CYCLES == 0) ? 2'd0 : 2'(TURN_CYCLES - 1);
  localparam logic [1:0] LastInit = 2'(NREQ - 1);

  if (NREQ < 2 || NREQ > NREQ_MAX || TURN_CYCLES > 3 || TIMEOUT < 1 || TIMEOUT > 255)
  begin : g_param_chk
    $error("scmp_bus_arb: parameter out of range");
  end

  arb_state_e      state_q;
  logic [NREQ-1:0] gnt_q;
  logic [1:0]      owner_q;
  logic [1:0]      last_q;
  logic [1:0]      turn_cnt_q;
  logic            busy_q;

  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] win_oh;
  logic [1:0]      win_idx;
  logic            win_vld;
  logic            own_req;
  logic            clear_gnt;
  logic            timeout_hit;

  // gnt is one-hot, so this is breq[owner] while a grant is held.
  assign own_req   = |(breq & gnt_q);
  assign clear_gnt = !bus_act && (state_q == StDrain || (state_q == StGrant && !own_req));

`ifdef SCMP_ARB_TIMEOUT_EN
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  logic [7:0]      tmo_cnt_q;
  logic [NREQ-1:0] mask_q;
  logic            to_flag_q;
  logic            tmo_q;

  assign cand        = breq & ~mask_q;
  assign timeout_hit = (state_q == StGrant) && own_req && (tmo_cnt_q == TmoLast);
  assign tmo         = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      mask_q    <= '0;
      to_flag_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q  <= clear_gnt && to_flag_q;
      // A timed-out owner stays masked until it drops its request.
      mask_q <= (mask_q & breq) | ((clear_gnt && to_flag_q) ? gnt_q : '0);
      if (state_q == StIdle && win_vld) begin
        tmo_cnt_q <= '0;
        to_flag_q <= 1'b0;
      end else if (state_q == StGrant && own_req && !timeout_hit) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
      if (timeout_hit) to_flag_q <= 1'b1;
    end
  end
`else
  assign cand        = breq;
  assign timeout_hit = 1'b0;
  assign tmo         = 1'b0;
`endif

  scmp_arb_rr #(
    .NREQ(NREQ)
  ) u_rr (
    .req    (cand),
    .last   (last_q),
    .win_oh (win_oh),
    .win_idx(win_idx),
    .win_vld(win_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      owner_q    <= '0;
      last_q     <= LastInit;
      turn_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else if (clear_gnt) begin
      gnt_q      <= '0;
      turn_cnt_q <= TurnLoad;
      if (TURN_CYCLES == 0) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        state_q <= StTurn;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_vld) begin
            state_q <= StGrant;
            gnt_q   <= win_oh;
            owner_q <= win_idx;
            last_q  <= win_idx;
            busy_q  <= 1'b1;
          end
        end
        // Reaching here with !own_req means bus_act is high: wait out the transfer.
        StGrant: if (!own_req || timeout_hit) state_q <= StDrain;
        StTurn: begin
          if (turn_cnt_q == 2'd0) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            turn_cnt_q <= turn_cnt_q - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule
